display_ram_ctrl: RTL and testbench
===================================

Name: display_ram_ctrl

Overview:
- Port-A controller for the 1K x 8 text display RAM: 64 columns x 16 rows, address = row*64 + col.
- Arbitrates between two requesters:
  - TRS-80 bus accesses: single-byte reads and writes.
  - A host-commanded fill/scroll engine: CLEAR screen, SCROLL up one row.
- Bus always wins. The engine uses idle cycles only.
- Port B stays with the video scan-out and is not touched.

Parameters:
- ROW_LEN, 64, bytes per text row.
- NUM_ROWS, 16, rows per screen.
- ADDR_W, 10, RAM address width; ROW_LEN*NUM_ROWS == 2**ADDR_W.

Ports:
- clk  in  1  system clock, also drives RAM clka.
- reset  in  1  asynchronous, active-high reset.
- bus_req  in  1  one-cycle access strobe from the bus decoder.
- bus_we  in  1  1 = write, 0 = read; qualified by bus_req.
- bus_addr  in  ADDR_W  bus byte address.
- bus_wdata  in  8  bus write data.
- bus_rdata  out  8  read data; valid while bus_ack is high.
- bus_ack  out  1  one-cycle pulse, exactly 1 cycle after bus_req.
- cmd_valid  in  1  host command strobe; accepted only while cmd_ready is high.
- cmd_op  in  2  0 NOP, 1 CLEAR, 2 SCROLL, 3 reserved (treated as NOP).
- cmd_fill  in  8  fill byte, latched on accept.
- cmd_ready  out  1  high in IDLE.
- busy  out  1  high from the cycle after accept until done.
- done  out  1  one-cycle completion pulse.
- ram_ce  out  1  RAM port-A cea.
- ram_we  out  1  RAM port-A wrea.
- ram_ad  out  ADDR_W  RAM port-A ada.
- ram_din  out  8  RAM port-A dina.
- ram_dout  in  8  RAM port-A douta; valid 1 cycle after a read with ce.

Behaviour:
- Reset (async, active-high):
  - state = IDLE.
  - bus_ack, done, busy, ram_ce, ram_we = 0.
  - bus_rdata, ram_ad, ram_din = 0.
  - cmd_ready = 1.
  - RAM contents are left unchanged.
- RAM port-A signals are combinational from the grant. ram_ocea is tied high outside this block.
- Grant: when bus_req = 1, the bus owns port A that cycle and the engine stalls with all its counters held.
- Bus write: ram_ce = ram_we = 1, ram_ad = bus_addr, ram_din = bus_wdata. bus_ack pulses next cycle.
- Bus read: ram_ce = 1, ram_we = 0. Next cycle: bus_ack = 1 and bus_rdata = ram_dout (registered on the same edge as the pulse, held until the next bus read).
- Back-to-back bus_req on consecutive cycles is legal; each gets its own ack.
- Command accept: cmd_valid && cmd_ready.
  - Latch op and fill; dst = 0.
  - NOP/reserved: done pulses the next cycle; busy stays 0.
- FSM states: IDLE, CLR, SC_RD, SC_WR, SC_FILL, FIN.
- CLR:
  - Each granted cycle writes fill to dst, then dst++.
  - After dst = 1023 is written, go to FIN.
  - Uncontended: 1024 cycles.
- SC_RD:
  - Granted cycle reads src = dst + ROW_LEN, sets the fresh flag, goes to SC_WR.
- SC_WR:
  - Granted cycle writes to dst, then dst++.
  - Data = ram_dout if fresh, else hold.
  - Goes to SC_RD, or to SC_FILL after dst = 959 is written.
- Data hold across preemption:
  - In the cycle after any granted engine read, hold is loaded from ram_dout.
  - If that cycle is preempted, fresh clears and the later write uses hold.
  - A bus read in between cannot corrupt hold, because douta only changes one cycle after the bus read.
- SC_FILL:
  - Writes fill to 960..1023, then goes to FIN.
  - Uncontended scroll total: 960*2 + 64 = 1984 cycles.
- FIN:
  - done = 1 and busy = 0 for one cycle, then IDLE with cmd_ready = 1.
- Bus writes during an engine operation commit immediately. The engine may overwrite them later; that ordering is architectural.
- Address arithmetic is ADDR_W-bit. src never exceeds 1023 because the last source is 959 + 64.
- cmd_valid while busy is ignored, with no queueing.
- Reset mid-operation aborts immediately. Partial RAM content remains.

Decomposition:
- Package display_pkg holds:
  - ROW_LEN, NUM_ROWS, ADDR_W.
  - op encodings OP_NOP/OP_CLEAR/OP_SCROLL.
  - the FSM state enum.
  - SCROLL_LAST_SRC (1023) and FILL_BASE (960).
- One natural sub-module: display_port_arb, the bus-vs-engine grant mux plus the bus_ack/bus_rdata pipeline. The engine FSM stays in display_ram_ctrl.

Test Plan:
- Bus write 0x41 to 0x005, then bus read 0x005: bus_ack one cycle after each req; on the read ack, bus_rdata = 0x41.
- CLEAR with fill 0x20, no bus traffic: busy for 1024 cycles, then done pulse; reading 0x000, 0x200 and 0x3FF returns 0x20; cmd_ready returns 1.
- Preload row r with byte 0x30+r, then SCROLL with fill 0x20: 1984 cycles to done; 0x000 = 0x31, 0x380 = 0x3F, 0x3C0..0x3FF = 0x20.
- SCROLL with bus_req asserted every 3rd cycle, including the cycle after an engine read: all bus acks on time; final RAM image identical to the uncontended scroll; done delayed by exactly the number of stolen cycles.
- Assert reset for 1 cycle at cycle 500 of a CLEAR: outputs return to reset values asynchronously; 0x000..0x1F3 hold fill, later addresses are untouched; a new CLEAR is accepted afterwards.
- cmd_op = 3 accepted: done pulses the next cycle, busy stays 0, no RAM writes; cmd_valid during a CLEAR is ignored.

Source files
------------

// File: rtl/display_pkg.sv
// Shared constants, opcodes, FSM states and the RAM port-A request bundle
// for the text display RAM controller.
package display_pkg;
  localparam int ROW_LEN  = 64;
  localparam int NUM_ROWS = 16;
  localparam int ADDR_W   = 10;

  localparam logic [1:0] OP_NOP    = 2'd0;
  localparam logic [1:0] OP_CLEAR  = 2'd1;
  localparam logic [1:0] OP_SCROLL = 2'd2;

  localparam logic [ADDR_W-1:0] LAST_ADDR       = ADDR_W'(ROW_LEN*NUM_ROWS-1);
  localparam logic [ADDR_W-1:0] SCROLL_LAST_SRC = ADDR_W'(1023);
  localparam logic [ADDR_W-1:0] FILL_BASE       = ADDR_W'(960);

  typedef enum logic [2:0] {IDLE, CLR, SC_RD, SC_WR, SC_FILL, FIN} state_t;

  typedef struct packed {
    logic              ce;
    logic              we;
    logic [ADDR_W-1:0] ad;
    logic [7:0]        din;
  } ram_req_t;
endpackage

// File: rtl/display_ram_ctrl_if.sv
// Bus-side and host-command handshake bundle of the display RAM controller.
interface display_bus_if;
  logic                           bus_req;
  logic                           bus_we;
  logic [display_pkg::ADDR_W-1:0] bus_addr;
  logic [7:0]                     bus_wdata;
  logic [7:0]                     bus_rdata;
  logic                           bus_ack;
  logic                           cmd_valid;
  logic [1:0]                     cmd_op;
  logic [7:0]                     cmd_fill;
  logic                           cmd_ready;
  logic                           busy;
  logic                           done;

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, cmd_valid, cmd_op, cmd_fill,
    output bus_rdata, bus_ack, cmd_ready, busy, done
  );
  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, cmd_valid, cmd_op, cmd_fill,
    input  bus_rdata, bus_ack, cmd_ready, busy, done
  );
endinterface

// File: rtl/display_port_arb.sv
// Port-A grant mux (bus has absolute priority over the engine) plus the
// one-cycle bus ack / read-data return path.
module display_port_arb
  import display_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              bus_req,
  input  logic              bus_we,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [7:0]        bus_wdata,
  input  ram_req_t          eng,
  output logic              eng_gnt,
  output logic              bus_ack,
  output logic [7:0]        bus_rdata,
  output ram_req_t          ram,
  input  logic [7:0]        ram_dout
);
  logic       rd_ack;
  logic [7:0] rdata_q;

  assign eng_gnt = !bus_req;

  always_comb begin
    ram = '0;
    if (bus_req)     ram = '{ce: 1'b1, we: bus_we, ad: bus_addr, din: bus_wdata};
    else if (eng.ce) ram = eng;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_ack <= 1'b0;
      rd_ack  <= 1'b0;
      rdata_q <= '0;
    end else begin
      bus_ack <= bus_req;
      rd_ack  <= bus_req && !bus_we;
      if (rd_ack) rdata_q <= ram_dout;
    end
  end

  // douta is only valid during the ack cycle; the register keeps it afterwards
  assign bus_rdata = rd_ack ? ram_dout : rdata_q;
endmodule

// File: rtl/display_ram_ctrl.sv
// Port-A controller for the 64x16 text RAM: TRS-80 bus accesses plus a
// CLEAR / SCROLL engine that only runs in cycles the bus leaves idle.
module display_ram_ctrl
  import display_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  display_bus_if.slave      host,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_ad,
  output logic [7:0]        ram_din,
  input  logic [7:0]        ram_dout
);
  state_t            state;
  logic [ADDR_W-1:0] dst, src;
  logic [7:0]        fill, hold;
  logic              fresh, gnt;
  ram_req_t          eng, ram;

  assign src = dst + ADDR_W'(ROW_LEN);

  always_comb begin
    eng = '0;
    case (state)
      CLR, SC_FILL: eng = '{ce: 1'b1, we: 1'b1, ad: dst, din: fill};
      SC_RD:        eng = '{ce: 1'b1, we: 1'b0, ad: src, din: 8'h00};
      SC_WR:        eng = '{ce: 1'b1, we: 1'b1, ad: dst, din: fresh ? ram_dout : hold};
      default:      eng = '0;
    endcase
  end

  display_port_arb u_arb (
    .clk      (clk),
    .reset    (reset),
    .bus_req  (host.bus_req),
    .bus_we   (host.bus_we),
    .bus_addr (host.bus_addr),
    .bus_wdata(host.bus_wdata),
    .eng      (eng),
    .eng_gnt  (gnt),
    .bus_ack  (host.bus_ack),
    .bus_rdata(host.bus_rdata),
    .ram      (ram),
    .ram_dout (ram_dout)
  );

  assign ram_ce  = ram.ce;
  assign ram_we  = ram.we;
  assign ram_ad  = ram.ad;
  assign ram_din = ram.din;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      dst            <= '0;
      fill           <= '0;
      hold           <= '0;
      fresh          <= 1'b0;
      host.busy      <= 1'b0;
      host.done      <= 1'b0;
      host.cmd_ready <= 1'b1;
    end else begin
      host.done <= 1'b0;
      // fresh marks the cycle right after a granted read; if that cycle is
      // stolen by the bus, the write later falls back to the captured hold.
      fresh <= 1'b0;
      if (fresh) hold <= ram_dout;
      case (state)
        IDLE: if (host.cmd_valid && host.cmd_ready) begin
          fill           <= host.cmd_fill;
          dst            <= '0;
          host.cmd_ready <= 1'b0;
          case (host.cmd_op)
            OP_CLEAR:  begin state <= CLR;   host.busy <= 1'b1; end
            OP_SCROLL: begin state <= SC_RD; host.busy <= 1'b1; end
            default:   begin state <= FIN;   host.done <= 1'b1; end
          endcase
        end
        CLR, SC_FILL: if (gnt) begin
          dst <= dst + 1'b1;
          if (dst == LAST_ADDR) begin
            state     <= FIN;
            host.busy <= 1'b0;
            host.done <= 1'b1;
          end
        end
        SC_RD: if (gnt) begin
          fresh <= 1'b1;
          state <= SC_WR;
        end
        SC_WR: if (gnt) begin
          dst   <= dst + 1'b1;
          state <= (dst == FILL_BASE - 1'b1) ? SC_FILL : SC_RD;
        end
        FIN: begin
          state          <= IDLE;
          host.cmd_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_display_ram_ctrl.sv
// Directed bench for display_ram_ctrl with a behavioural 1Kx8 port-A RAM.
module tb_display_ram_ctrl;
  import display_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              ram_ce, ram_we;
  logic [ADDR_W-1:0] ram_ad;
  logic [7:0]        ram_din, ram_dout;
  logic [7:0]        mem [0:1023];
  int                n_chk = 0, n_pass = 0;
  int                wr_cnt = 0;

  display_bus_if dif();

  display_ram_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .host    (dif),
    .ram_ce  (ram_ce),
    .ram_we  (ram_we),
    .ram_ad  (ram_ad),
    .ram_din (ram_din),
    .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_ce) begin
      if (ram_we) begin
        mem[ram_ad] <= ram_din;
        wr_cnt      <= wr_cnt + 1;
      end else ram_dout <= mem[ram_ad];
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  function automatic logic [7:0] pat(input int mode, input int a);
    case (mode)
      0:       return 8'(8'h30 + a / 64);
      1:       return 8'(a * 7 + 3);
      default: return 8'hEE;
    endcase
  endfunction

  function automatic logic [7:0] exp_scroll(input int mode, input logic [7:0] f, input int a);
    return (a < 960) ? pat(mode, a + 64) : f;
  endfunction

  task automatic bus_op(input string tag, input logic we, input int a,
                        input logic [7:0] d, input logic [7:0] exp_rd);
    dif.bus_req = 1'b1; dif.bus_we = we; dif.bus_addr = 10'(a); dif.bus_wdata = d;
    @(negedge clk);
    dif.bus_req = 1'b0;
    chk({tag, "_ack"}, dif.bus_ack, 1);
    if (!we) chk({tag, "_rd"}, dif.bus_rdata, exp_rd);
    @(negedge clk);
    chk({tag, "_ack_drop"}, dif.bus_ack, 0);
  endtask

  // back-to-back bus writes, one per cycle
  task automatic fill_ram(input int mode);
    int bad = 0;
    for (int a = 0; a < 1024; a++) begin
      dif.bus_req = 1'b1; dif.bus_we = 1'b1; dif.bus_addr = 10'(a); dif.bus_wdata = pat(mode, a);
      @(negedge clk);
      if (dif.bus_ack !== 1'b1) bad++;
    end
    dif.bus_req = 1'b0; dif.bus_we = 1'b0;
    @(negedge clk);
    chk("preload_ack", bad, 0);
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] f);
    dif.cmd_valid = 1'b1; dif.cmd_op = op; dif.cmd_fill = f;
    @(negedge clk);
    dif.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input bit contend, output int cnt, output int stolen);
    int k = 0, bad = 0;
    logic prev = 1'b0;
    cnt = 0; stolen = 0;
    while (dif.done !== 1'b1 && k < 6000) begin
      if (dif.bus_ack !== prev) bad++;
      if (dif.busy === 1'b1) cnt++;
      dif.bus_req  = contend && (k % 3 == 0);
      dif.bus_we   = 1'b0;
      dif.bus_addr = 10'(k);
      if (dif.bus_req && dif.busy) stolen++;
      prev = dif.bus_req;
      k++;
      @(negedge clk);
    end
    dif.bus_req = 1'b0;
    if (dif.bus_ack !== prev) bad++;
    chk("done_seen", dif.done, 1);
    chk("done_busy", dif.busy, 0);
    chk("ack_timing", bad, 0);
  endtask

  task automatic chk_image(input string tag, input int mode, input logic [7:0] f, input bit scrolled);
    int bad = 0;
    for (int a = 0; a < 1024; a++)
      if (mem[a] !== (scrolled ? exp_scroll(mode, f, a) : f)) bad++;
    chk(tag, bad, 0);
  endtask

  initial begin
    int cnt, st, bad, w0;
    reset = 1'b1;
    dif.bus_req = 0; dif.bus_we = 0; dif.bus_addr = '0; dif.bus_wdata = '0;
    dif.cmd_valid = 0; dif.cmd_op = '0; dif.cmd_fill = '0;
    repeat (2) @(negedge clk);
    chk("rst_ack", dif.bus_ack, 0);
    chk("rst_done", dif.done, 0);
    chk("rst_busy", dif.busy, 0);
    chk("rst_ready", dif.cmd_ready, 1);
    chk("rst_ram", {ram_ce, ram_we, ram_ad, ram_din}, 0);
    chk("rst_rdata", dif.bus_rdata, 0);
    reset = 1'b0;
    @(negedge clk);

    // single write then read-back
    bus_op("wr005", 1'b1, 5, 8'h41, 8'h00);
    bus_op("rd005", 1'b0, 5, 8'h00, 8'h41);
    chk("rdata_held", dif.bus_rdata, 8'h41);

    // uncontended CLEAR
    issue(OP_CLEAR, 8'h20);
    chk("clr_busy", dif.busy, 1);
    chk("clr_ready", dif.cmd_ready, 0);
    wait_done(1'b0, cnt, st);
    chk("clr_cycles", cnt, 1024);
    @(negedge clk);
    chk("clr_ready_back", dif.cmd_ready, 1);
    chk("clr_done_drop", dif.done, 0);
    bus_op("clr_rd000", 1'b0, 12'h000, 8'h00, 8'h20);
    bus_op("clr_rd200", 1'b0, 12'h200, 8'h00, 8'h20);
    bus_op("clr_rd3ff", 1'b0, 12'h3FF, 8'h00, 8'h20);

    // uncontended SCROLL of row-tagged screen
    fill_ram(0);
    issue(OP_SCROLL, 8'h20);
    wait_done(1'b0, cnt, st);
    chk("sc_cycles", cnt, 1984);
    @(negedge clk);
    bus_op("sc_rd000", 1'b0, 12'h000, 8'h00, 8'h31);
    bus_op("sc_rd380", 1'b0, 12'h380, 8'h00, 8'h3F);
    bus_op("sc_rd3c0", 1'b0, 12'h3C0, 8'h00, 8'h20);
    chk_image("sc_image", 0, 8'h20, 1'b1);

    // SCROLL with a bus read stolen every third cycle
    fill_ram(1);
    issue(OP_SCROLL, 8'h5A);
    wait_done(1'b1, cnt, st);
    chk("scc_stole", st > 600, 1);
    chk("scc_cycles", cnt, 1984 + st);
    @(negedge clk);
    chk_image("scc_image", 1, 8'h5A, 1'b1);

    // reset in cycle 500 of a CLEAR
    fill_ram(2);
    issue(OP_CLEAR, 8'h55);
    repeat (500) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("arst_busy", dif.busy, 0);
    chk("arst_ready", dif.cmd_ready, 1);
    chk("arst_ram", {ram_ce, ram_we, ram_ad, ram_din}, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    bad = 0;
    for (int a = 0; a < 1024; a++)
      if (mem[a] !== ((a < 500) ? 8'h55 : 8'hEE)) bad++;
    chk("arst_image", bad, 0);
    issue(OP_CLEAR, 8'h00);
    chk("arst_reaccept", dif.busy, 1);
    wait_done(1'b0, cnt, st);
    chk("arst_clr_cycles", cnt, 1024);
    @(negedge clk);
    chk_image("arst_clr_image", 0, 8'h00, 1'b0);

    // reserved opcode behaves as NOP
    w0 = wr_cnt;
    issue(2'd3, 8'hAA);
    chk("nop_done", dif.done, 1);
    chk("nop_busy", dif.busy, 0);
    @(negedge clk);
    chk("nop_ready", dif.cmd_ready, 1);
    chk("nop_done_drop", dif.done, 0);
    chk("nop_no_write", wr_cnt - w0, 0);

    // command strobe during CLEAR is dropped
    issue(OP_CLEAR, 8'h11);
    repeat (10) @(negedge clk);
    dif.cmd_valid = 1'b1; dif.cmd_op = OP_SCROLL; dif.cmd_fill = 8'h99;
    repeat (5) @(negedge clk);
    chk("ign_ready", dif.cmd_ready, 0);
    dif.cmd_valid = 1'b0;
    wait_done(1'b0, cnt, st);
    chk("ign_cycles", cnt, 1009);
    @(negedge clk);
    chk("ign_idle", dif.busy, 0);
    chk_image("ign_image", 0, 8'h11, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
